// File: rtl/min_sec_counter.sv
// rtl/min_sec_counter.sv - BCD seconds/minutes counter with prescaler, time-set load and hour pulse
module min_sec_counter #(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       tick,
    output logic       hour_ena
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [7:0]    r_ss;
    logic [7:0]    r_mm;
    logic          w_tick;
    logic          w_hour_ena;
    logic          w_ss_wrap;

    // Digit-wise 00..59 increment; never forms a binary value wider than a nibble.
    function automatic logic [7:0] bcd59_inc(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (lo == 4'd9) begin
            lo = 4'd0;
            hi = (hi == 4'd5) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    function automatic logic bcd59_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    always_comb begin
        w_tick     = run & ~reset & ~load & (r_presc == PRESC_MAX);
        w_ss_wrap  = (r_ss == 8'h59);
        w_hour_ena = w_tick & w_ss_wrap & (r_mm == 8'h59);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_ss    <= 8'h00;
            r_mm    <= 8'h00;
        end else if (load) begin
            r_presc <= '0;
            r_ss    <= bcd59_valid(load_ss) ? load_ss : 8'h00;
            r_mm    <= bcd59_valid(load_mm) ? load_mm : 8'h00;
        end else if (w_tick) begin
            r_presc <= '0;
            r_ss    <= bcd59_inc(r_ss);
            if (w_ss_wrap) begin
                r_mm <= bcd59_inc(r_mm);
            end
        end else if (run) begin
            r_presc <= r_presc + PW'(1);
        end
    end

    assign mm       = r_mm;
    assign ss       = r_ss;
    assign tick     = w_tick;
    assign hour_ena = w_hour_ena;

endmodule
